// File: rtl/spi_mem_target.sv
// SPI target register file: deserialises LSB-first write/read frames from cs_n/mosi
// into a DEPTH x 8-bit memory and returns read data on miso after a ready pulse.
module spi_mem_target #(
  parameter int unsigned DEPTH = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cs_n,
  input  logic mosi,
  output logic miso,
  output logic ready,
  output logic op_done,
  output logic frame_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] RECV       = 3'd1;
  localparam logic [2:0] EXEC       = 3'd2;
  localparam logic [2:0] RESP_READY = 3'd3;
  localparam logic [2:0] RESP_SHIFT = 3'd4;

  logic [2:0]  state;
  logic        cs_q;
  logic [4:0]  cnt;
  logic [16:0] frame;
  logic [7:0]  shreg;
  logic [3:0]  shcnt;
  logic [7:0]  mem [DEPTH];

  logic [7:0]  addr;
  logic [7:0]  data;
  logic        addr_ok;
  logic        capture;

  assign addr    = frame[8:1];
  assign data    = frame[16:9];
  assign addr_ok = ({24'd0, addr} < DEPTH);
  assign capture = ~cs_n & ~cs_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cs_q      <= 1'b1;
      cnt       <= '0;
      frame     <= '0;
      shreg     <= '0;
      shcnt     <= '0;
      miso      <= 1'b0;
      ready     <= 1'b0;
      op_done   <= 1'b0;
      frame_err <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      cs_q      <= cs_n;
      ready     <= 1'b0;
      op_done   <= 1'b0;
      frame_err <= 1'b0;

      case (state)
        IDLE: begin
          if (!cs_n) begin
            state <= RECV;
            frame <= '0;
            cnt   <= '0;
            // With a one-cycle inter-frame gap the setup cycle falls in EXEC,
            // so the first data bit already arrives here.
            if (capture) begin
              frame[0] <= mosi;
              cnt      <= 5'd1;
            end
          end
        end

        RECV: begin
          if (cs_n) begin
            state <= EXEC;
          end else if (capture) begin
            if (cnt < 5'd17) frame[cnt] <= mosi;
            if (cnt < 5'd18) cnt <= cnt + 5'd1;
          end
        end

        EXEC: begin
          if (cnt == 5'd17 && frame[0]) begin
            if (addr_ok) mem[addr[AW-1:0]] <= data;
            op_done <= 1'b1;
            state   <= IDLE;
          end else if (cnt == 5'd9 && !frame[0]) begin
            shreg <= addr_ok ? mem[addr[AW-1:0]] : 8'h00;
            state <= RESP_READY;
          end else begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end
        end

        RESP_READY: begin
          ready <= 1'b1;
          shcnt <= '0;
          state <= RESP_SHIFT;
        end

        RESP_SHIFT: begin
          if (shcnt < 4'd8) begin
            miso  <= shreg[0];
            shreg <= shreg >> 1;
            shcnt <= shcnt + 4'd1;
          end else begin
            miso  <= 1'b0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mem_target.sv
// Directed bench for spi_mem_target: frame-level stimulus with hand-computed
// expected bytes and cycle-exact pulse timing checks.
module tb_spi_mem_target;

  logic clk = 1'b0;
  logic rst_n, cs_n, mosi;
  logic miso, ready, op_done, frame_err;

  int n_vec = 0;
  int n_err = 0;
  int n_op  = 0;
  int n_rdy = 0;
  int n_fe  = 0;

  spi_mem_target #(.DEPTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso),
    .ready     (ready),
    .op_done   (op_done),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (op_done)   n_op++;
    if (ready)     n_rdy++;
    if (frame_err) n_fe++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Leaves the caller just after edge E, where cs_n was first sampled high.
  task automatic send_bits(input logic [17:0] f, input int unsigned n);
    cs_n = 1'b0;
    mosi = 1'b0;
    step();
    for (int unsigned i = 0; i < n; i++) begin
      mosi = f[i];
      step();
    end
    cs_n = 1'b1;
    mosi = 1'b0;
    step();
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input bit fast);
    send_bits({1'b0, d, a, 1'b1}, 17);
    if (!fast) begin
      chk("op_done@E", {31'd0, op_done}, 32'd0);
      step();
      chk("op_done@E+1", {31'd0, op_done}, 32'd1);
      step();
      chk("op_done@E+2", {31'd0, op_done}, 32'd0);
    end
  endtask

  task automatic do_read(input logic [7:0] a, input int abort_k, output logic [7:0] d);
    send_bits({9'd0, a, 1'b0}, 9);
    d = '0;
    step();
    chk("ready@E+1", {31'd0, ready}, 32'd0);
    step();
    chk("ready@E+2", {31'd0, ready}, 32'd1);
    for (int k = 0; k < 8; k++) begin
      step();
      d[k] = miso;
      if (k == 0) chk("ready@E+3", {31'd0, ready}, 32'd0);
      if (k == abort_k) begin
        rst_n = 1'b0;
        step();
        chk("rst_read_outs", {28'd0, miso, ready, op_done, frame_err}, 32'd0);
        rst_n = 1'b1;
        step();
        return;
      end
    end
    step();
    chk("miso_idle@E+11", {31'd0, miso}, 32'd0);
  endtask

  task automatic read_expect(input string tag, input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] d;
    do_read(a, -1, d);
    chk(tag, {24'd0, d}, {24'd0, exp});
  endtask

  initial begin
    int op0, rdy0, fe0;
    logic [7:0] d;
    logic [17:0] f;

    rst_n = 1'b0;
    cs_n  = 1'b1;
    mosi  = 1'b0;
    step();
    step();
    chk("reset_outs", {28'd0, miso, ready, op_done, frame_err}, 32'd0);
    rst_n = 1'b1;
    step();

    // Read of untouched top address after reset
    fe0 = n_fe;
    read_expect("rd31_after_reset", 8'd31, 8'h00);
    step();
    chk("no_err_rd31", n_fe - fe0, 0);

    // Write A5 to 3 then read back
    op0 = n_op; rdy0 = n_rdy;
    do_write(8'd3, 8'hA5, 1'b0);
    read_expect("rd3_A5", 8'd3, 8'hA5);
    step();
    chk("op_cnt_wr3", n_op - op0, 1);
    chk("rdy_cnt_rd3", n_rdy - rdy0, 1);

    // Out-of-range write: acked, no aliasing
    op0 = n_op;
    do_write(8'd40, 8'h3C, 1'b0);
    chk("op_cnt_wr40", n_op - op0, 1);
    read_expect("rd40_oor", 8'd40, 8'h00);
    read_expect("rd8_no_alias", 8'd8, 8'h00);

    // Short frame: 5 bits captured
    op0 = n_op; rdy0 = n_rdy; fe0 = n_fe;
    send_bits(18'b10011, 5);
    chk("short_ferr@E", {31'd0, frame_err}, 32'd0);
    step();
    chk("short_ferr@E+1", {31'd0, frame_err}, 32'd1);
    step();
    chk("short_ferr@E+2", {31'd0, frame_err}, 32'd0);
    // 18-bit write frame aimed at addr 3
    f = {1'b1, 8'h11, 8'd3, 1'b1};
    send_bits(f, 18);
    step();
    chk("long_ferr@E+1", {31'd0, frame_err}, 32'd1);
    step();
    step();
    chk("err_cnt", n_fe - fe0, 2);
    chk("err_no_op", n_op - op0, 0);
    chk("err_no_rdy", n_rdy - rdy0, 0);
    read_expect("rd3_unchanged", 8'd3, 8'hA5);

    // Reset at bit 10 of a write to addr 5
    op0 = n_op;
    f = {1'b0, 8'h77, 8'd5, 1'b1};
    cs_n = 1'b0;
    step();
    for (int i = 0; i < 10; i++) begin
      mosi = f[i];
      step();
    end
    mosi  = f[10];
    rst_n = 1'b0;
    step();
    chk("rst_write_outs", {28'd0, miso, ready, op_done, frame_err}, 32'd0);
    rst_n = 1'b1;
    cs_n  = 1'b1;
    mosi  = 1'b0;
    step();
    step();
    chk("rst_write_no_op", n_op - op0, 0);
    read_expect("rd5_after_abort", 8'd5, 8'h00);
    do_write(8'd5, 8'h77, 1'b0);
    read_expect("rd5_after_rewrite", 8'd5, 8'h77);

    // Reset at miso bit 4 of a read of addr 6
    do_write(8'd6, 8'h5A, 1'b0);
    do_read(8'd6, 4, d);
    chk("rd6_bits_before_abort", {28'd0, d[3:0]}, 32'hA);
    step();
    read_expect("rd6_cleared", 8'd6, 8'h00);
    do_write(8'd6, 8'hC3, 1'b0);
    read_expect("rd6_after_rewrite", 8'd6, 8'hC3);

    // Back-to-back writes with minimum gap, then full read-back
    step();
    op0 = n_op; rdy0 = n_rdy; fe0 = n_fe;
    for (int unsigned a = 0; a < 32; a++) begin
      do_write(a[7:0], ~a[7:0], 1'b1);
    end
    step();
    step();
    for (int unsigned a = 0; a < 32; a++) begin
      read_expect($sformatf("b2b_rd%0d", a), a[7:0], ~a[7:0]);
    end
    step();
    chk("b2b_op_cnt", n_op - op0, 32);
    chk("b2b_rdy_cnt", n_rdy - rdy0, 32);
    chk("b2b_err_cnt", n_fe - fe0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
